// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: a shift-register scoreboard of in-flight
// destination tags drives per-source forward selects, forwarded operands,
// the load-use stall and the stall-cycle counter.
module fwd_hazard_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   hold,
  input  logic                                   flush,
  input  logic                                   issue_valid,
  input  logic                                   issue_wen,
  input  logic [REG_AW-1:0]                      issue_wsel,
  input  logic                                   issue_load,
  input  logic [NSRC*REG_AW-1:0]                 src_sel,
  input  logic [NSRC*DATA_W-1:0]                 rf_data,
  input  logic [DEPTH*DATA_W-1:0]                stage_data,
  output logic [NSRC*DATA_W-1:0]                 opnd,
  output logic [NSRC*$clog2(DEPTH+1)-1:0]        fwd_sel,
  output logic                                   stall,
  output logic [CNT_W-1:0]                       stall_cnt
);

  localparam int unsigned SEL_W = $clog2(DEPTH + 1);
  // Load data never becomes available beyond the last tracked entry; with
  // DEPTH=1 a load therefore never forwards and stalls until it retires.
  localparam int unsigned LS_EFF = (LOAD_STAGE >= DEPTH) ? DEPTH : LOAD_STAGE;

  typedef struct packed {
    logic              vld;
    logic              wen;
    logic [REG_AW-1:0] wsel;
    logic              load;
  } sb_entry_t;

  sb_entry_t          sb_q [DEPTH];
  sb_entry_t          sb_d [DEPTH];
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;

  logic               stall_raw;
  logic               hit;
  logic               unready;
  logic [SEL_W-1:0]   sel;
  logic [REG_AW-1:0]  src;

  // Per-source resolution: the youngest matching entry decides both the
  // forward path and whether the source has to wait for load data.
  always_comb begin
    fwd_sel   = '0;
    opnd      = rf_data;
    stall_raw = 1'b0;
    hit       = 1'b0;
    unready   = 1'b0;
    sel       = '0;
    src       = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      src     = src_sel[k*REG_AW +: REG_AW];
      hit     = 1'b0;
      unready = 1'b0;
      sel     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!hit && sb_q[i].vld && sb_q[i].wen &&
            (sb_q[i].wsel == src) && (src != '0)) begin
          hit     = 1'b1;
          sel     = SEL_W'(i + 1);
          unready = sb_q[i].load && (i < LS_EFF);
          opnd[k*DATA_W +: DATA_W] = stage_data[i*DATA_W +: DATA_W];
        end
      end
      fwd_sel[k*SEL_W +: SEL_W] = sel;
      stall_raw = stall_raw | (hit & unready);
    end
  end

  assign stall     = stall_raw & ~flush;
  assign stall_cnt = stall_cnt_q;

  // Scoreboard advance: freeze on hold, otherwise shift with either the
  // issuing instruction or a bubble (flush / load-use stall) into entry 0.
  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int unsigned i = DEPTH - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      if (flush || stall_raw) begin
        sb_d[0] = '0;
      end else begin
        sb_d[0] = {issue_valid, issue_wen, issue_wsel, issue_load};
      end
      if (!flush && stall_raw && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sb_q[i] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Parametrised forwarding and hazard controller for the 5-stage pipeline. It supersedes the fixed two-source, two-stage combinational forwarding logic.
It keeps a shift-register scoreboard of the destination tags of every in-flight instruction past decode. From that it produces a per-source forward select and the forwarded operand, a load-use stall, and a flush bubble.
It sits between the decode/execute pipeline register and the ALU operand muxes, and is generalised in source count, tracked depth and load latency.

Parameters:
DATA_W, 32, operand width
REG_AW, 5, register index width
NSRC, 2, number of source operands checked per issue
DEPTH, 3, tracked in-flight stages; entry 0 = EX, 1 = MEM, 2 = WB
LOAD_STAGE, 2, first entry index at which load data is valid (1 <= LOAD_STAGE < DEPTH)
CNT_W, 16, stall counter width

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
hold  in  1  global freeze (cache miss); scoreboard does not move
flush  in  1  kill the issuing instruction (branch/jump taken)
issue_valid  in  1  decode stage holds a real instruction
issue_wen  in  1  issuing instruction writes a register
issue_wsel  in  REG_AW  destination register of the issuing instruction
issue_load  in  1  issuing instruction is a load
src_sel  in  NSRC*REG_AW  source register indices, source k at [k*REG_AW +: REG_AW]
rf_data  in  NSRC*DATA_W  register-file read data per source
stage_data  in  DEPTH*DATA_W  result data of entry i (ALU out, mem/writeback data)
opnd  out  NSRC*DATA_W  resolved operand per source
fwd_sel  out  NSRC*($clog2(DEPTH+1))  per source: 0 = register file, i+1 = entry i
stall  out  1  load-use hazard; decode and fetch must hold
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard entry fields: {vld, wen, wsel, load}. Entry i is "ready" when load==0 or i >= LOAD_STAGE.
- Match rule: entry i matches source k when vld & wen & (wsel == src_k) & (src_k != 0). Register 0 is never forwarded.
- fwd_sel and opnd are combinational from the registered scoreboard, src_sel, rf_data and stage_data. Latency is 0 cycles.
- Source k selects the lowest-index (youngest) matching entry. With no match, fwd_sel=0 and opnd=rf_data.
- stall=1 when any source's youngest match is not ready. Older ready matches never override a younger unready one.
- stall is forced to 0 while flush=1. When stall=1, opnd values are don't-care.
- Sequential update on posedge CLK, with priority RST > hold > flush > stall > normal:
  - RST: all vld=0, stall_cnt=0.
  - hold: scoreboard and stall_cnt unchanged. stall is still evaluated and driven.
  - flush: entries shift (entry i+1 <= entry i) and entry 0 <= bubble (vld=0).
  - stall: shift as above with a bubble into entry 0. stall_cnt increments, saturating at all-ones.
  - normal: shift, and entry 0 <= {issue_valid, issue_wen, issue_wsel, issue_load}.
- The oldest entry (DEPTH-1) is discarded on every shift.
- Reset values: every entry invalid. Therefore stall=0, all fwd_sel=0, opnd=rf_data, stall_cnt=0.
- If hold and stall are both asserted, stall_cnt does not increment. Only advancing stall cycles are counted.
- Duplicate sources (src_0 == src_1) resolve independently and identically.
- A load whose entry reaches LOAD_STAGE clears the stall in that cycle; the dependent then issues.
- A single load-use therefore stalls for LOAD_STAGE cycles when the dependent sits directly behind the load.
- Reset asserted mid-stall clears all state on the next edge; stall drops to 0 in the following cycle.
- DEPTH=1 is legal. Only EX forwarding is possible, and LOAD_STAGE must then be treated as DEPTH (loads never forward; stall until retired).

Test Plan:
1. ALU chain: issue add r3; next cycle issue a source with src_0=3, stage_data[0]=0x0000_00AA -> fwd_sel_0=1, opnd_0=0xAA, stall=0.
2. Load-use: issue lw r4, then a dependent with src_1=4 (defaults) -> stall=1 for 2 cycles, stall_cnt=2. Then fwd_sel_1=3, opnd_1=stage_data[2].
3. Youngest wins: r5 is written by entries 0 and 1 with stage_data 0x11 and 0x22 -> opnd=0x11, fwd_sel=1. Make entry 0 a load (unready) -> stall=1.
4. Register zero: entry 0 writes r0, src_0=0, rf_data_0=0 -> fwd_sel_0=0, opnd_0=0.
5. Hold during stall: load-use stall with hold=1 for 5 cycles -> stall stays 1, scoreboard frozen, stall_cnt unchanged. Release hold -> resolves after 2 more cycles.
6. Flush and reset: flush while stall=1 -> stall=0 and entry 0 bubble next cycle. Assert RST with 3 valid entries -> next cycle all fwd_sel=0, stall_cnt=0.
